// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. Owns the program counter, issues sequential
// reads to a synchronous instruction memory (1-cycle read latency), buffers
// the returned {pc, instruction} pairs in a small FIFO and presents the FIFO
// head to decode over a valid/ready handshake. A redirect from the EX-stage
// branch unit flushes the FIFO, kills the in-flight response and restarts
// fetching at the (word-aligned) target in the same cycle.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset (priority over all)
//   redirect_i     taken branch/jal/jalr from EX
//   redirect_pc_i  redirect target byte address (low 2 bits ignored)
//   imem_req_o     instruction-memory read request this cycle
//   imem_addr_o    instruction-memory byte address
//   imem_rdata_i   read data, valid exactly 1 cycle after a request
//   if_valid_o     FIFO head holds a valid instruction
//   if_pc_o        PC of the head instruction (0 when empty)
//   if_instr_o     head instruction (0 when empty, acts as a bubble)
//   id_ready_i     decode accepts the head
//   fifo_count_o   number of occupied FIFO entries
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_i,
    input  logic [PC_W-1:0]              redirect_pc_i,
    output logic                         imem_req_o,
    output logic [PC_W-1:0]              imem_addr_o,
    input  logic [INS_W-1:0]             imem_rdata_i,
    output logic                         if_valid_o,
    output logic [PC_W-1:0]              if_pc_o,
    output logic [INS_W-1:0]             if_instr_o,
    input  logic                         id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc_q;
    logic [PC_W-1:0]  fetch_pc_d;
    logic             inflight_q;
    logic             inflight_d;
    logic [PC_W-1:0]  inflight_pc_q;
    logic [PC_W-1:0]  inflight_pc_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [INS_W-1:0] ins_mem_q [DEPTH];

    logic [PC_W-1:0]  redirect_pc_aligned_s;
    logic [CNT_W:0]   occupancy_s;
    logic             issue_s;
    logic             enq_s;
    logic             deq_s;
    logic             if_valid_s;
    logic             unused_s;

    // Word-align the redirect target; the dropped low bits never raise an exception.
    assign redirect_pc_aligned_s = {redirect_pc_i[PC_W-1:2], 2'b00};
    assign unused_s              = ^redirect_pc_i[1:0];

    // Queued entries plus the outstanding request: issuing only below DEPTH
    // guarantees that an arriving response always finds a free slot.
    assign occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign if_valid_s  = (count_q != '0);

    // Request generation: reset silences the port, redirect overrides the issue rule.
    always_comb begin
        issue_s     = 1'b0;
        imem_addr_o = '0;
        if (reset) begin
            issue_s     = 1'b0;
            imem_addr_o = '0;
        end else if (redirect_i) begin
            issue_s     = 1'b1;
            imem_addr_o = redirect_pc_aligned_s;
        end else begin
            issue_s     = (occupancy_s < DEPTH_C);
            imem_addr_o = fetch_pc_q;
        end
        imem_req_o = issue_s;
    end

    // Next-state logic for PC, in-flight tracking and FIFO bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        enq_s         = 1'b0;
        deq_s         = 1'b0;
        if (redirect_i) begin
            // Flush: the previous cycle's response is dropped by not enqueuing
            // it, and a coincident handshake is not a pop.
            fetch_pc_d    = redirect_pc_aligned_s + PC_W'(3'd4);
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_pc_aligned_s;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
        end else begin
            enq_s      = inflight_q;
            deq_s      = if_valid_s && id_ready_i;
            inflight_d = issue_s;
            if (issue_s) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_W'(3'd4);
            end else begin
                inflight_pc_d = inflight_pc_q;
                fetch_pc_d    = fetch_pc_q;
            end
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers and FIFO storage; reset clears everything including in-flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (enq_s) begin
                pc_mem_q[wr_ptr_q]  <= inflight_pc_q;
                ins_mem_q[wr_ptr_q] <= imem_rdata_i;
            end
        end
    end

    // Head presentation: an empty FIFO shows an all-zero bubble.
    always_comb begin
        if_valid_o   = if_valid_s;
        fifo_count_o = count_q;
        if (if_valid_s) begin
            if_pc_o    = pc_mem_q[rd_ptr_q];
            if_instr_o = ins_mem_q[rd_ptr_q];
        end else begin
            if_pc_o    = '0;
            if_instr_o = '0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               redirect_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic               imem_req_o;
    logic [PC_W-1:0]    imem_addr_o;
    logic [INS_W-1:0]   imem_rdata_i;
    logic               if_valid_o;
    logic [PC_W-1:0]    if_pc_o;
    logic [INS_W-1:0]   if_instr_o;
    logic               id_ready_i;
    logic [CNT_W-1:0]   fifo_count_o;

    fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .id_ready_i   (id_ready_i),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [INS_W-1:0] ref_instr(input logic [PC_W-1:0] a);
        return 32'h0000_0013 | (32'(a) << 20);
    endfunction

    function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

    // Instruction memory: data for the address presented last cycle.
    logic [PC_W-1:0] last_addr_q;
    always @(posedge clk) last_addr_q <= imem_addr_o;
    assign imem_rdata_i = ref_instr(last_addr_q);

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] next_fetch;
    logic            prev_req;
    int              max_count;
    int              first_req_cyc;
    int              first_valid_cyc;
    logic [PC_W-1:0] dlv_pc[$];
    int              dlv_cyc[$];

    // One clock cycle: check the reference model against the DUT, then advance.
    task automatic tick();
        logic            exp_req;
        logic [PC_W-1:0] exp_addr;
        #1;
        if (reset) begin
            n_checks++;
            if (imem_req_o !== 1'b0 || imem_addr_o !== '0)
                $display("FAIL req_in_reset: req=%b addr=%h, required 0/000", imem_req_o, imem_addr_o);
            else n_pass++;
            exp_pc     = '0;
            next_fetch = '0;
            prev_req   = 1'b0;
        end else begin
            exp_req = redirect_i || ((int'(fifo_count_o) + int'(prev_req)) < DEPTH);
            n_checks++;
            if (imem_req_o !== exp_req)
                $display("FAIL issue_rule: cyc=%0d req=%b, required %b (count=%0d)", cyc, imem_req_o, exp_req, fifo_count_o);
            else n_pass++;
            if (exp_req) begin
                exp_addr = redirect_i ? align(redirect_pc_i) : next_fetch;
                n_checks++;
                if (imem_addr_o !== exp_addr)
                    $display("FAIL issue_addr: cyc=%0d addr=%h, required %h", cyc, imem_addr_o, exp_addr);
                else n_pass++;
                next_fetch = exp_addr + 9'd4;
            end
            prev_req = exp_req;
            if (redirect_i) begin
                exp_pc = align(redirect_pc_i);
            end else if (if_valid_o && id_ready_i) begin
                n_checks++;
                if (if_pc_o !== exp_pc || if_instr_o !== ref_instr(exp_pc))
                    $display("FAIL stream_order: cyc=%0d pc=%h instr=%h, required pc=%h instr=%h",
                             cyc, if_pc_o, if_instr_o, exp_pc, ref_instr(exp_pc));
                else n_pass++;
                dlv_pc.push_back(if_pc_o);
                dlv_cyc.push_back(cyc);
                exp_pc = exp_pc + 9'd4;
            end
        end
        n_checks++;
        if (int'(fifo_count_o) > DEPTH || if_valid_o !== (fifo_count_o != '0) ||
            (!if_valid_o && (if_pc_o !== '0 || if_instr_o !== '0)))
            $display("FAIL fifo_state: cyc=%0d count=%0d valid=%b pc=%h instr=%h, required count<=%0d and empty=>zero head",
                     cyc, fifo_count_o, if_valid_o, if_pc_o, if_instr_o, DEPTH);
        else n_pass++;
        if (int'(fifo_count_o) > max_count) max_count = int'(fifo_count_o);
        if (!reset && imem_req_o && first_req_cyc < 0) first_req_cyc = cyc;
        if (if_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_log();
        dlv_pc.delete();
        dlv_cyc.delete();
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        max_count       = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_i = 1'b0;
        tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (if_valid_o !== 1'b0 || if_pc_o !== '0 || if_instr_o !== '0 || fifo_count_o !== '0 ||
            imem_req_o !== 1'b0 || imem_addr_o !== '0)
            $display("FAIL reset_state: valid=%b pc=%h instr=%h count=%0d req=%b addr=%h, required all 0",
                     if_valid_o, if_pc_o, if_instr_o, fifo_count_o, imem_req_o, imem_addr_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        id_ready_i = 1'b1;
        do_reset();
        repeat (8) tick();
        n_checks++;
        if (first_req_cyc < 0 || first_valid_cyc - first_req_cyc != 2)
            $display("FAIL req_to_valid_latency: %0d, required 2", first_valid_cyc - first_req_cyc);
        else n_pass++;
        n_checks++;
        if (dlv_pc.size() < 4)
            $display("FAIL stream_count: %0d delivered, required >=4", dlv_pc.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dlv_pc[i] !== 9'(4 * i) || dlv_cyc[i] != dlv_cyc[0] + i)
                    $display("FAIL stream_pc%0d: pc=%h at cyc %0d, required %h at cyc %0d",
                             i, dlv_pc[i], dlv_cyc[i], 9'(4 * i), dlv_cyc[0] + i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        id_ready_i = 1'b0;
        do_reset();
        repeat (10) tick();
        n_checks++;
        if (max_count != DEPTH || fifo_count_o !== CNT_W'(DEPTH) || imem_req_o !== 1'b0)
            $display("FAIL full_fifo: max=%0d count=%0d req=%b, required %0d/%0d/0",
                     max_count, fifo_count_o, imem_req_o, DEPTH, DEPTH);
        else n_pass++;
        id_ready_i = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (dlv_pc.size() < 5)
            $display("FAIL drain_count: %0d delivered, required >=5", dlv_pc.size());
        else begin
            n_pass++;
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (dlv_pc[i] !== 9'(4 * i))
                    $display("FAIL drain_pc%0d: %h, required %h", i, dlv_pc[i], 9'(4 * i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_redirect_flush();
        bit found;
        id_ready_i = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fifo_count_o == 3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) $display("FAIL fill_three: count=%0d, required 3 within 20 cycles", fifo_count_o);
        else n_pass++;
        clear_log();
        redirect_i = 1'b1; redirect_pc_i = 9'h040; id_ready_i = 1'b1;
        #1;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 9'h040)
            $display("FAIL redirect_issue: req=%b addr=%h, required 1/040", imem_req_o, imem_addr_o);
        else n_pass++;
        tick();
        redirect_i = 1'b0;
        n_checks++;
        if (fifo_count_o !== '0 || if_valid_o !== 1'b0)
            $display("FAIL flush: count=%0d valid=%b, required 0/0", fifo_count_o, if_valid_o);
        else n_pass++;
        tick();
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 9'h040)
            $display("FAIL redirect_latency: valid=%b pc=%h, required 1/040", if_valid_o, if_pc_o);
        else n_pass++;
        repeat (6) tick();
        n_checks++;
        if (dlv_pc.size() == 0 || dlv_pc[0] !== 9'h040)
            $display("FAIL redirect_first: size=%0d, required first pc 040", dlv_pc.size());
        else n_pass++;
        foreach (dlv_pc[i]) begin
            n_checks++;
            if (dlv_pc[i] >= 9'h00C && dlv_pc[i] <= 9'h01C)
                $display("FAIL stale_pc: %h delivered, required none of 00C..01C", dlv_pc[i]);
            else n_pass++;
        end
    endtask

    task automatic redirect_and_check(input logic [PC_W-1:0] target, input int n);
        logic [PC_W-1:0] base;
        base = align(target);
        clear_log();
        id_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = target;
        #1;
        n_checks++;
        if (imem_addr_o !== base)
            $display("FAIL aligned_addr: %h, required %h", imem_addr_o, base);
        else n_pass++;
        tick();
        redirect_i = 1'b0;
        repeat (n + 3) tick();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (dlv_pc.size() <= i || dlv_pc[i] !== base + 9'(4 * i))
                $display("FAIL target_stream%0d: size=%0d, required pc %h", i, dlv_pc.size(), base + 9'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        redirect_and_check(9'h043, 2);
    endtask

    task automatic test_wrap();
        redirect_and_check(9'h1FC, 3);
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] tgt;
        clear_log();
        id_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tgt = 9'($urandom_range(0, 511));
            redirect_i = 1'b1; redirect_pc_i = tgt;
            tick();
        end
        redirect_i = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (dlv_pc.size() < 2 || dlv_pc[0] !== align(tgt) || dlv_pc[1] !== align(tgt) + 9'd4)
            $display("FAIL back_to_back: size=%0d, required %h then %h", dlv_pc.size(), align(tgt), align(tgt) + 9'd4);
        else n_pass++;
    endtask

    task automatic test_random();
        clear_log();
        for (int i = 0; i < 400; i++) begin
            id_ready_i    = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = 9'($urandom_range(0, 511));
            tick();
        end
        redirect_i = 1'b0;
        n_checks++;
        if (dlv_pc.size() < 50)
            $display("FAIL random_progress: %0d delivered, required >=50", dlv_pc.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        id_ready_i = 1'b0;
        do_reset();
        repeat (8) tick();
        n_checks++;
        if (fifo_count_o !== CNT_W'(DEPTH))
            $display("FAIL prefill: count=%0d, required %0d", fifo_count_o, DEPTH);
        else n_pass++;
        reset = 1'b1; redirect_i = 1'b1; redirect_pc_i = 9'h080;
        tick();
        n_checks++;
        if (if_valid_o !== 1'b0 || if_pc_o !== '0 || if_instr_o !== '0 || fifo_count_o !== '0 ||
            imem_req_o !== 1'b0 || imem_addr_o !== '0)
            $display("FAIL mid_reset: valid=%b pc=%h instr=%h count=%0d req=%b addr=%h, required all 0",
                     if_valid_o, if_pc_o, if_instr_o, fifo_count_o, imem_req_o, imem_addr_o);
        else n_pass++;
        tick();
        reset = 1'b0; redirect_i = 1'b0;
        clear_log();
        #1;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== '0)
            $display("FAIL post_reset_req: req=%b addr=%h, required 1/000", imem_req_o, imem_addr_o);
        else n_pass++;
        id_ready_i = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (dlv_pc.size() == 0 || dlv_pc[0] !== 9'h000)
            $display("FAIL post_reset_stream: size=%0d, required first pc 000", dlv_pc.size());
        else n_pass++;
    endtask

    initial begin
        clear_log();
        exp_pc = '0; next_fetch = '0; prev_req = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that owns the program counter and feeds the IF/ID pipeline register. It issues sequential requests to the synchronous instruction memory, which has 1-cycle read latency.
- It buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- The EX-stage branch unit redirects it. A redirect flushes the FIFO and kills any in-flight response.

Parameters:
- PC_W, 9, PC / instruction-memory byte-address width
- INS_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- redirect_i  in  1  taken branch/jal/jalr from EX (PcSel)
- redirect_pc_i  in  PC_W  redirect target byte address
- imem_req_o  out  1  instruction-memory read request this cycle
- imem_addr_o  out  PC_W  instruction-memory byte address
- imem_rdata_i  in  INS_W  read data; valid exactly 1 cycle after a request
- if_valid_o  out  1  FIFO head holds a valid instruction
- if_pc_o  out  PC_W  PC of the head instruction
- if_instr_o  out  INS_W  head instruction
- id_ready_i  in  1  decode accepts the head (low = Reg_Stall)
- fifo_count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset (priority over all): fetch_pc=0, FIFO empty, in-flight cleared.
  - Outputs: if_valid_o=0, if_pc_o=0, if_instr_o=0, fifo_count_o=0, imem_req_o=0, imem_addr_o=0.
  - Applies mid-operation too; a response arriving the cycle after reset is discarded.
- Issue rule, no redirect: imem_req_o=1 when fifo_count + inflight < DEPTH.
  - imem_addr_o=fetch_pc.
  - On issue, fetch_pc <= fetch_pc+4, modulo 2^PC_W (0x1FC -> 0x000).
  - inflight is 1 bit: at most one outstanding request, since latency is 1.
- Response: the cycle after an un-killed request, {addr, imem_rdata_i} is written at the FIFO tail.
  - It is visible at the head no earlier than the following cycle; no bypass.
  - Request to if_valid_o latency is 2 cycles.
- Dequeue: pop when if_valid_o && id_ready_i. Enqueue and dequeue in the same cycle keeps the count unchanged.
  - Because the issue rule counts inflight, an enqueue never finds the FIFO full.
  - Steady state with id_ready_i=1: one instruction per cycle.
- Empty: if_valid_o=0, if_pc_o=0, if_instr_o=0 (zero instruction acts as bubble, matching the flush convention).
- Redirect (priority over issue, enqueue and dequeue):
  - FIFO cleared and count goes to 0 next cycle.
  - The response of a request issued the previous cycle is dropped (kill flag).
  - In the same cycle: imem_req_o=1, imem_addr_o={redirect_pc_i[PC_W-1:2],2'b00}, fetch_pc <= that aligned value +4.
  - Redirect to if_valid_o latency is 2 cycles.
  - A handshake coincident with redirect is not counted as a pop; decode is flushed by the same event.
- Back-to-back redirects: each cancels the previous one; only the last target's stream appears.
- Misaligned target: low 2 bits forced to 0; no exception.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count never exceeds DEPTH; the bench asserts this.
- Order invariant: delivered if_pc_o sequence = sequential +4 stream, restarted at each redirect target. No duplicates, no gaps.

Test Plan:
- Reset release, id_ready_i=1, imem returns 0x00000013|addr<<20 → if_valid_o rises 2 cycles after first req; if_pc_o = 0x000,0x004,0x008,0x00C on consecutive cycles.
- id_ready_i=0 from the first valid cycle for 8 cycles → fifo_count_o saturates at 4, imem_req_o=0 while full. Release → PCs 0x000..0x00C, then 0x010; no loss or duplicates.
- With 3 entries queued and 1 in flight, pulse redirect_i with redirect_pc_i=0x040 → next cycle fifo_count_o=0, if_valid_o=0. Two cycles after the redirect, if_pc_o=0x040; no stale PC (0x00C..0x01C) ever appears.
- redirect_pc_i=0x043 → imem_addr_o=0x040 that cycle; delivered PCs 0x040, 0x044.
- redirect_pc_i=0x1FC → delivered PCs 0x1FC, 0x000, 0x004 (wrap).
- reset asserted with full FIFO and redirect_i=1 in the same cycle → next cycle all outputs 0, fifo_count_o=0. The first request after release is to 0x000.
